div_unit: RTL and testbench

Parametrised iterative integer divider for the execute stage of the pipelined MIPS core. It computes quotient (LO) and remainder (HI) for DIV/DIVU one bit per cycle. It raises a stall request so the pipeline holds the instruction in E until the result is ready. It supports signed and unsigned modes, divide-by-zero flagging and flush cancellation.

---
 rtl/div_unit.sv | 123 ++++++++++++
 tb/tb_div_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle, with
// sign fix-up, divide-by-zero flagging, pipeline stall request and flush cancel.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             cancel_i,
  output logic             stall_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             dbz_o
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [CW-1:0]    r_cnt;
  logic             r_qneg;
  logic             r_rneg;
  logic             r_dbz;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic             r_dbz_out;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_lo_fix;
  logic [WIDTH-1:0] w_hi_fix;

  assign w_a_neg = signed_i & dividend_i[WIDTH-1];
  assign w_b_neg = signed_i & divisor_i[WIDTH-1];
  assign w_a_abs = w_a_neg ? -dividend_i : dividend_i;
  assign w_b_abs = w_b_neg ? -divisor_i  : divisor_i;

  // Shifted partial remainder needs WIDTH+1 bits; MSB of the difference is the borrow.
  assign w_trial = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_div};

  assign w_lo_fix = r_qneg ? -r_quo : r_quo;
  // With a zero divisor the remainder ends as |dividend|; re-applying the
  // dividend sign restores the operand exactly as sampled.
  assign w_hi_fix = r_rneg ? -r_rem : r_rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rem     <= '0;
      r_quo     <= '0;
      r_div     <= '0;
      r_cnt     <= '0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_dbz     <= 1'b0;
      r_lo      <= '0;
      r_hi      <= '0;
      r_dbz_out <= 1'b0;
    end else if (cancel_i) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_quo   <= w_a_abs;
            r_div   <= w_b_abs;
            r_rem   <= '0;
            r_qneg  <= w_a_neg ^ w_b_neg;
            r_rneg  <= w_a_neg;
            r_dbz   <= (divisor_i == '0);
            r_cnt   <= CW'(WIDTH - 1);
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          if (w_trial[WIDTH]) begin
            r_rem <= {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
          end else begin
            r_rem <= w_trial[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
          end
          if (r_cnt == '0) begin
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_FIX: begin
          r_lo      <= r_dbz ? '1 : w_lo_fix;
          r_hi      <= w_hi_fix;
          r_dbz_out <= r_dbz;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign stall_o = (r_state == S_CALC) | (r_state == S_FIX) |
                   ((r_state == S_IDLE) & start_i & ~cancel_i);
  assign valid_o = (r_state == S_DONE) & ~cancel_i;
  assign lo_o    = r_lo;
  assign hi_o    = r_hi;
  assign dbz_o   = r_dbz_out;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver pushes reference results, a monitor
// pops and compares them (value and arrival cycle) whenever valid_o fires.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        cancel_i;
  logic        stall_o;
  logic        valid_o;
  logic [31:0] lo_o;
  logic [31:0] hi_o;
  logic        dbz_o;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .cancel_i(cancel_i),
    .stall_o(stall_o), .valid_o(valid_o), .lo_o(lo_o), .hi_o(hi_o), .dbz_o(dbz_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dbz;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc    = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: MIPS DIV/DIVU semantics from plain 64-bit arithmetic.
  function automatic exp_t model(input bit s, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb_, q, r;
    e.cyc = 0;
    if (b == 32'd0) begin
      e.lo = 32'hFFFF_FFFF;
      e.hi = a;
      e.dbz = 1'b1;
    end else begin
      if (s) begin
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
      end else begin
        sa  = {32'd0, a};
        sb_ = {32'd0, b};
      end
      q = sa / sb_;
      r = sa % sb_;
      e.lo = q[31:0];
      e.hi = r[31:0];
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    #1;
    if (valid_o) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 64'(valid_o), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("lo", 64'(lo_o), 64'(e.lo));
        check("hi", 64'(hi_o), 64'(e.hi));
        check("dbz", 64'(dbz_o), 64'(e.dbz));
        check("latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Called at a negedge in IDLE; returns at the negedge following DONE.
  task automatic do_op(input bit s, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    int unsigned n;
    start_i = 1'b1;
    signed_i = s;
    dividend_i = a;
    divisor_i = b;
    e = model(s, a, b);
    e.cyc = cyc + 34;
    sb.push_back(e);
    #1;
    check("stall_start", 64'(stall_o), 64'd1);
    n = 1;
    @(negedge clk);
    start_i = 1'b0;
    dividend_i = $urandom;
    divisor_i = $urandom;
    #1;
    while (stall_o && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("stall_len", 64'(n), 64'd34);
    check("valid_at_stall_drop", 64'(valid_o), 64'd1);
    @(negedge clk);
  endtask

  logic [31:0] save_lo, save_hi;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    start_i = 1'b0;
    signed_i = 1'b0;
    dividend_i = '0;
    divisor_i = '0;
    cancel_i = 1'b0;
    #12;
    check("rst_lo", 64'(lo_o), 64'd0);
    check("rst_hi", 64'(hi_o), 64'd0);
    check("rst_dbz", 64'(dbz_o), 64'd0);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_stall", 64'(stall_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_op(1'b0, 32'd100, 32'd7);
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2);
    do_op(1'b1, 32'd7, 32'hFFFF_FFFE);
    do_op(1'b0, 32'h1234, 32'd0);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(1'b1, 32'hFFFF_FF00, 32'd0);
    do_op(1'b0, 32'hFFFF_FFFF, 32'd1);

    // Cancel mid-operation, then restart immediately.
    save_lo = lo_o;
    save_hi = hi_o;
    start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd1000; divisor_i = 32'd3;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    cancel_i = 1'b1;
    @(negedge clk);
    cancel_i = 1'b0;
    #1;
    check("cancel_stall", 64'(stall_o), 64'd0);
    check("cancel_lo_hold", 64'(lo_o), 64'(save_lo));
    check("cancel_hi_hold", 64'(hi_o), 64'(save_hi));
    do_op(1'b0, 32'd9, 32'd3);

    // start together with cancel in IDLE is not accepted.
    start_i = 1'b1; cancel_i = 1'b1; dividend_i = 32'd50; divisor_i = 32'd5;
    #1;
    check("start_cancel_stall", 64'(stall_o), 64'd0);
    @(negedge clk);
    start_i = 1'b0; cancel_i = 1'b0;
    #1;
    check("start_cancel_idle", 64'(stall_o), 64'd0);
    @(negedge clk);

    // Reset in the middle of an operation.
    start_i = 1'b1; signed_i = 1'b1; dividend_i = 32'd12345; divisor_i = 32'd17;
    @(negedge clk);
    start_i = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_lo", 64'(lo_o), 64'd0);
    check("midrst_hi", 64'(hi_o), 64'd0);
    check("midrst_valid", 64'(valid_o), 64'd0);
    check("midrst_stall", 64'(stall_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_op(1'b0, 32'hFFFF_FFFF, 32'h10);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = $urandom_range(1, 20);
        2: b = -$urandom_range(1, 20);
        default: b = $urandom;
      endcase
      do_op(1'($urandom_range(0, 1)), a, b);
    end

    repeat (40) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
